mem_arbiter: RTL and testbench

- Sits directly downstream of the instruction and data caches and merges their two cache-side memory ports onto the single shared memory port.
- Arbitrates one transaction at a time, with round-robin fairness, and holds the grant until that transaction completes.
- Routes response beats back to the owning cache.
- The icache port is read-only; the dcache port carries reads (line refills) and writes (128-bit dirty-block writebacks).

---
 rtl/mem_arbiter_if.sv | 60 ++++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and shared memory ports seen by the arbiter.
// The arbiter uses the slave view; the caches and the memory model use the
// master view.
interface mem_arbiter_if #(
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_ADDR_BITS = 28
);
    // icache port (read-only)
    logic                       ic_req_valid;
    logic                       ic_req_ready;
    logic [MEM_ADDR_BITS-1:0]   ic_req_addr;
    logic                       ic_resp_valid;
    logic [MEM_DATA_BITS-1:0]   ic_resp_data;

    // dcache port (line refills and dirty-block writebacks)
    logic                       dc_req_valid;
    logic                       dc_req_ready;
    logic [MEM_ADDR_BITS-1:0]   dc_req_addr;
    logic                       dc_req_rw;
    logic                       dc_req_data_valid;
    logic                       dc_req_data_ready;
    logic [MEM_DATA_BITS-1:0]   dc_req_data_bits;
    logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask;
    logic                       dc_resp_valid;
    logic [MEM_DATA_BITS-1:0]   dc_resp_data;

    // shared memory port
    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic [MEM_ADDR_BITS-1:0]   mem_req_addr;
    logic                       mem_req_rw;
    logic                       mem_req_data_valid;
    logic                       mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0]   mem_req_data_bits;
    logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask;
    logic                       mem_resp_valid;
    logic [MEM_DATA_BITS-1:0]   mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_addr, dc_req_rw,
        input  dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
        output dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_rw,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_addr, dc_req_rw,
        output dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
        input  dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_rw,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Merges the icache and dcache memory ports onto one shared memory port.
// One transaction at a time, round-robin between the caches, grant held
// until the transaction completes. Request and data paths are purely
// combinational pass-throughs; only the arbitration state is registered.
module mem_arbiter #(
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_ADDR_BITS = 28,
    parameter int READ_BEATS    = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    localparam int CNT_BITS = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t              state_reg;
    logic                owner_dc_reg;     // 1 = dcache owns the RD transaction
    logic                rr_dc_first_reg;  // 1 = dcache wins the next tie
    logic [CNT_BITS-1:0] beat_cnt_reg;
    logic                req_done_reg;
    logic                data_done_reg;

    logic in_idle, in_rd, in_wr;
    logic sel_dc, sel_ic, wr_sel;
    logic req_window, data_window;
    logic req_fire, data_fire;
    logic [MEM_ADDR_BITS-1:0] req_addr;
    logic [MEM_DATA_BITS-1:0] resp_data;

    assign in_idle = (state_reg == IDLE);
    assign in_rd   = (state_reg == RD);
    assign in_wr   = (state_reg == WR);

    // Selection only exists in IDLE; a tie goes to the port not granted last.
    assign sel_dc = in_idle && bus.dc_req_valid && (!bus.ic_req_valid || rr_dc_first_reg);
    assign sel_ic = in_idle && bus.ic_req_valid && !sel_dc;
    assign wr_sel = sel_dc && bus.dc_req_rw;

    // Request channel is open for a fresh selection or an unfinished write.
    assign req_window  = sel_dc || sel_ic || (in_wr && !req_done_reg);
    // Write data channel is open while a write is selected or still owed data.
    assign data_window = wr_sel || (in_wr && !data_done_reg);

    assign req_fire  = req_window && bus.mem_req_ready;
    assign data_fire = data_window && bus.dc_req_data_valid && bus.mem_req_data_ready;

    // In WR only the dcache can be the source, so any non-icache selection routes dcache.
    assign req_addr = sel_ic ? bus.ic_req_addr : bus.dc_req_addr;

    assign bus.mem_req_valid = req_window;
    assign bus.mem_req_addr  = req_addr;
    assign bus.mem_req_rw    = wr_sel || (in_wr && !req_done_reg);
    assign bus.ic_req_ready  = sel_ic && bus.mem_req_ready;
    assign bus.dc_req_ready  = (sel_dc || (in_wr && !req_done_reg)) && bus.mem_req_ready;

    assign bus.mem_req_data_valid = data_window && bus.dc_req_data_valid;
    assign bus.dc_req_data_ready  = data_window && bus.mem_req_data_ready;
    assign bus.mem_req_data_bits  = bus.dc_req_data_bits;
    assign bus.mem_req_data_mask  = bus.dc_req_data_mask;

    // Response data is broadcast; only the owner of a read sees valid.
    assign resp_data         = bus.mem_resp_data;
    assign bus.ic_resp_data  = resp_data;
    assign bus.dc_resp_data  = resp_data;
    assign bus.ic_resp_valid = in_rd && !owner_dc_reg && bus.mem_resp_valid;
    assign bus.dc_resp_valid = in_rd &&  owner_dc_reg && bus.mem_resp_valid;

    // Arbitration FSM: grant tracking, read beat counting, write completion flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            owner_dc_reg    <= 1'b0;
            rr_dc_first_reg <= 1'b1;
            beat_cnt_reg    <= '0;
            req_done_reg    <= 1'b0;
            data_done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_fire) begin
                        rr_dc_first_reg <= !sel_dc;
                    end
                    if (wr_sel) begin
                        // A write completing both handshakes at once never leaves IDLE.
                        if ((req_fire || data_fire) && !(req_fire && data_fire)) begin
                            state_reg     <= WR;
                            req_done_reg  <= req_fire;
                            data_done_reg <= data_fire;
                        end
                    end else if (req_fire) begin
                        state_reg    <= RD;
                        owner_dc_reg <= sel_dc;
                        beat_cnt_reg <= '0;
                    end
                end
                RD: begin
                    if (bus.mem_resp_valid) begin
                        if (beat_cnt_reg == CNT_BITS'(READ_BEATS - 1)) begin
                            state_reg    <= IDLE;
                            beat_cnt_reg <= '0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                WR: begin
                    if (req_fire) begin
                        rr_dc_first_reg <= 1'b0;
                    end
                    if ((req_done_reg || req_fire) && (data_done_reg || data_fire)) begin
                        state_reg     <= IDLE;
                        req_done_reg  <= 1'b0;
                        data_done_reg <= 1'b0;
                    end else begin
                        req_done_reg  <= req_done_reg || req_fire;
                        data_done_reg <= data_done_reg || data_fire;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table covering reads and
// arbitration, followed by hand-written write and reset sequences.
module tb_mem_arbiter;
    localparam int DB = 128;
    localparam int AB = 28;
    localparam int RB = 4;

    localparam logic [AB-1:0] ADDR_A = 28'h0000123;
    localparam logic [AB-1:0] ADDR_B = 28'h0000456;
    localparam logic [AB-1:0] ADDR_C = 28'h00ABCDE;
    localparam logic [DB-1:0] WDATA  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [DB/8-1:0] WMASK = 16'h0F0F;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.MEM_DATA_BITS(DB), .MEM_ADDR_BITS(AB)) bus ();

    mem_arbiter #(.MEM_DATA_BITS(DB), .MEM_ADDR_BITS(AB), .READ_BEATS(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic          rst, icv, dcv, mrdy, rv;
        logic [DB-1:0] rd;
        logic          eic, edc, emv;
        logic [AB-1:0] ema;
        logic          eicrv, edcrv;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [DB-1:0] beat(input int k);
        return {4{32'hD0D0_0000 + 32'(k)}};
    endfunction

    function automatic vec_t mk(input logic rst, icv, dcv, mrdy, rv, input int k,
                                input logic eic, edc, emv, input logic [AB-1:0] ema,
                                input logic eicrv, edcrv);
        vec_t v;
        v.rst = rst; v.icv = icv; v.dcv = dcv; v.mrdy = mrdy; v.rv = rv;
        v.rd = beat(k);
        v.eic = eic; v.edc = edc; v.emv = emv; v.ema = ema;
        v.eicrv = eicrv; v.edcrv = edcrv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        reset                  = 1'b0;
        bus.ic_req_valid       = 1'b0;
        bus.ic_req_addr        = '0;
        bus.dc_req_valid       = 1'b0;
        bus.dc_req_addr        = '0;
        bus.dc_req_rw          = 1'b0;
        bus.dc_req_data_valid  = 1'b0;
        bus.dc_req_data_bits   = '0;
        bus.dc_req_data_mask   = '0;
        bus.mem_req_ready      = 1'b0;
        bus.mem_req_data_ready = 1'b0;
        bus.mem_resp_valid     = 1'b0;
        bus.mem_resp_data      = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);

        // rst icv dcv mrdy rv k | eic edc emv ema eicrv edcrv
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, '0,     0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, '0,     0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   1, 0, 1, ADDR_A, 0, 0)); // ic read granted
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   0, 0, 0, '0,     1, 0)); // D0
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 0, '0,     0, 0)); // gap
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   0, 0, 0, '0,     1, 0)); // D1
        vecs.push_back(mk(0, 0, 0, 1, 1, 2,   0, 0, 0, '0,     1, 0)); // D2
        vecs.push_back(mk(0, 0, 0, 1, 1, 3,   0, 0, 0, '0,     1, 0)); // D3
        vecs.push_back(mk(0, 1, 0, 0, 1, 9,   0, 0, 1, ADDR_A, 0, 0)); // IDLE again, stray beat dropped
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, '0,     0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,   0, 1, 1, ADDR_B, 0, 0)); // tie: dcache first
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 0, 1, 1, 20 + k, 0, 0, 0, '0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,   1, 0, 1, ADDR_A, 0, 0)); // tie: icache now
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 1, 1, 1, 30 + k, 0, 0, 0, '0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0, 1, ADDR_B, 0, 0)); // tie: dcache again

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clear_inputs();
            reset              = vecs[i].rst;
            bus.ic_req_valid   = vecs[i].icv;
            bus.ic_req_addr    = ADDR_A;
            bus.dc_req_valid   = vecs[i].dcv;
            bus.dc_req_addr    = ADDR_B;
            bus.mem_req_ready  = vecs[i].mrdy;
            bus.mem_resp_valid = vecs[i].rv;
            bus.mem_resp_data  = vecs[i].rd;
            #1;
            chk($sformatf("v%0d ic_req_ready", i), bus.ic_req_ready, vecs[i].eic);
            chk($sformatf("v%0d dc_req_ready", i), bus.dc_req_ready, vecs[i].edc);
            chk($sformatf("v%0d mem_req_valid", i), bus.mem_req_valid, vecs[i].emv);
            if (vecs[i].emv) chk($sformatf("v%0d mem_req_addr", i), bus.mem_req_addr, vecs[i].ema);
            if (vecs[i].emv || vecs[i].rst) chk($sformatf("v%0d mem_req_rw", i), bus.mem_req_rw, 1'b0);
            chk($sformatf("v%0d mem_req_data_valid", i), bus.mem_req_data_valid, 1'b0);
            chk($sformatf("v%0d dc_req_data_ready", i), bus.dc_req_data_ready, 1'b0);
            chk($sformatf("v%0d ic_resp_valid", i), bus.ic_resp_valid, vecs[i].eicrv);
            chk($sformatf("v%0d dc_resp_valid", i), bus.dc_resp_valid, vecs[i].edcrv);
            if (vecs[i].eicrv) chk($sformatf("v%0d ic_resp_data", i), bus.ic_resp_data, vecs[i].rd);
            if (vecs[i].edcrv) chk($sformatf("v%0d dc_resp_data", i), bus.dc_resp_data, vecs[i].rd);
            $display("vec %0d applied (checks so far %0d)", i, n_chk);
        end

        // Write: request first, data two cycles later.
        do_reset();
        @(negedge clk); clear_inputs();
        bus.dc_req_valid = 1; bus.dc_req_rw = 1; bus.dc_req_addr = ADDR_C;
        bus.mem_req_ready = 1; bus.mem_req_data_ready = 1;
        #1;
        chk("w1 req mem_req_valid", bus.mem_req_valid, 1'b1);
        chk("w1 req mem_req_rw", bus.mem_req_rw, 1'b1);
        chk("w1 req mem_req_addr", bus.mem_req_addr, ADDR_C);
        chk("w1 req dc_req_ready", bus.dc_req_ready, 1'b1);
        chk("w1 req mem_req_data_valid", bus.mem_req_data_valid, 1'b0);
        chk("w1 req dc_req_data_ready", bus.dc_req_data_ready, 1'b1);
        @(negedge clk); clear_inputs();
        bus.mem_req_ready = 1; bus.mem_req_data_ready = 1; bus.mem_resp_valid = 1;
        #1;
        chk("w1 wait mem_req_valid", bus.mem_req_valid, 1'b0);
        chk("w1 wait dc_req_ready", bus.dc_req_ready, 1'b0);
        chk("w1 wait dc_req_data_ready", bus.dc_req_data_ready, 1'b1);
        chk("w1 wait dc_resp_valid", bus.dc_resp_valid, 1'b0);
        chk("w1 wait ic_resp_valid", bus.ic_resp_valid, 1'b0);
        @(negedge clk); clear_inputs();
        bus.mem_req_data_ready = 1; bus.dc_req_data_valid = 1;
        bus.dc_req_data_bits = WDATA; bus.dc_req_data_mask = WMASK;
        #1;
        chk("w1 data mem_req_data_valid", bus.mem_req_data_valid, 1'b1);
        chk("w1 data mem_req_data_bits", bus.mem_req_data_bits, WDATA);
        chk("w1 data mem_req_data_mask", bus.mem_req_data_mask, WMASK);
        chk("w1 data mem_req_valid", bus.mem_req_valid, 1'b0);
        @(negedge clk); clear_inputs();
        bus.ic_req_valid = 1; bus.ic_req_addr = ADDR_A; bus.mem_req_data_ready = 1;
        #1;
        chk("w1 idle mem_req_valid", bus.mem_req_valid, 1'b1);
        chk("w1 idle mem_req_addr", bus.mem_req_addr, ADDR_A);
        chk("w1 idle mem_req_rw", bus.mem_req_rw, 1'b0);
        chk("w1 idle dc_req_data_ready", bus.dc_req_data_ready, 1'b0);
        $display("seq write-late-data done");

        // Write: request and data in the same cycle, icache waiting.
        do_reset();
        @(negedge clk); clear_inputs();
        bus.dc_req_valid = 1; bus.dc_req_rw = 1; bus.dc_req_addr = ADDR_C;
        bus.dc_req_data_valid = 1; bus.dc_req_data_bits = WDATA;
        bus.ic_req_valid = 1; bus.ic_req_addr = ADDR_A;
        bus.mem_req_ready = 1; bus.mem_req_data_ready = 1;
        #1;
        chk("w2 dc_req_ready", bus.dc_req_ready, 1'b1);
        chk("w2 ic_req_ready", bus.ic_req_ready, 1'b0);
        chk("w2 mem_req_data_valid", bus.mem_req_data_valid, 1'b1);
        chk("w2 mem_req_rw", bus.mem_req_rw, 1'b1);
        @(negedge clk); clear_inputs();
        bus.ic_req_valid = 1; bus.ic_req_addr = ADDR_A;
        bus.dc_req_valid = 1; bus.dc_req_addr = ADDR_B; bus.mem_req_ready = 1;
        #1;
        chk("w2 next mem_req_addr", bus.mem_req_addr, ADDR_A);
        chk("w2 next ic_req_ready", bus.ic_req_ready, 1'b1);
        chk("w2 next dc_req_ready", bus.dc_req_ready, 1'b0);
        $display("seq write-same-cycle done");

        // Write: data accepted before the request.
        do_reset();
        @(negedge clk); clear_inputs();
        bus.dc_req_valid = 1; bus.dc_req_rw = 1; bus.dc_req_addr = ADDR_C;
        bus.dc_req_data_valid = 1; bus.mem_req_data_ready = 1;
        #1;
        chk("w3 first dc_req_ready", bus.dc_req_ready, 1'b0);
        chk("w3 first dc_req_data_ready", bus.dc_req_data_ready, 1'b1);
        @(negedge clk); clear_inputs();
        bus.dc_req_valid = 1; bus.dc_req_rw = 1; bus.dc_req_addr = ADDR_C;
        bus.dc_req_data_valid = 1; bus.mem_req_ready = 1; bus.mem_req_data_ready = 1;
        #1;
        chk("w3 req mem_req_valid", bus.mem_req_valid, 1'b1);
        chk("w3 req mem_req_rw", bus.mem_req_rw, 1'b1);
        chk("w3 req dc_req_ready", bus.dc_req_ready, 1'b1);
        chk("w3 req mem_req_data_valid", bus.mem_req_data_valid, 1'b0);
        @(negedge clk); clear_inputs();
        bus.ic_req_valid = 1; bus.ic_req_addr = ADDR_A;
        #1;
        chk("w3 idle mem_req_addr", bus.mem_req_addr, ADDR_A);
        $display("seq write-early-data done");

        // Reset after two beats of a read, then a fresh read.
        do_reset();
        @(negedge clk); clear_inputs();
        bus.ic_req_valid = 1; bus.ic_req_addr = ADDR_A; bus.mem_req_ready = 1;
        #1; chk("r first ic_req_ready", bus.ic_req_ready, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); clear_inputs();
            bus.mem_resp_valid = 1; bus.mem_resp_data = beat(40 + k);
            #1; chk($sformatf("r beat%0d ic_resp_valid", k), bus.ic_resp_valid, 1'b1);
        end
        @(negedge clk); clear_inputs();
        reset = 1; bus.mem_resp_valid = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); clear_inputs();
            bus.mem_resp_valid = 1; bus.mem_resp_data = beat(50 + k);
            #1;
            chk($sformatf("r stale%0d ic_resp_valid", k), bus.ic_resp_valid, 1'b0);
            chk($sformatf("r stale%0d dc_resp_valid", k), bus.dc_resp_valid, 1'b0);
        end
        @(negedge clk); clear_inputs();
        bus.ic_req_valid = 1; bus.ic_req_addr = ADDR_A; bus.mem_req_ready = 1;
        #1; chk("r fresh ic_req_ready", bus.ic_req_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); clear_inputs();
            bus.mem_resp_valid = 1; bus.mem_resp_data = beat(60 + k);
            #1;
            chk($sformatf("r fresh%0d ic_resp_valid", k), bus.ic_resp_valid, 1'b1);
            chk($sformatf("r fresh%0d ic_resp_data", k), bus.ic_resp_data, beat(60 + k));
        end
        @(negedge clk); clear_inputs();
        bus.mem_resp_valid = 1;
        #1; chk("r extra ic_resp_valid", bus.ic_resp_valid, 1'b0);
        $display("seq reset-mid-read done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
